// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI RAM master: frame commands,
// controller state encoding and default frame geometry.
package spi_ram_pkg;

    localparam int CMD_W = 2;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    // Default frame word width: command bits on top of an 8-bit payload.
    localparam int DEF_ADDR_W = 8;
    localparam int FRAME_W    = DEF_ADDR_W + CMD_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_ram_master_shifter.sv
// Frame datapath: parallel-load MOSI shifter, MISO capture shifter and the
// shared bit counter that tells the controller where a frame/capture ends.
module spi_frame_shifter
    import spi_ram_pkg::*;
#(
    parameter int FW     = FRAME_W,
    parameter int DATA_W = FRAME_W - CMD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [FW-1:0]     load_word,
    input  logic              frame_en,
    input  logic              cap_en,
    input  logic              miso,
    output logic              mosi,
    output logic              frame_last,
    output logic              cap_last,
    output logic [DATA_W-1:0] cap_next
);

    localparam int CNT_W = $clog2(FW + 1);
    localparam logic [CNT_W-1:0] CNT_FRAME_END = CNT_W'(FW);
    localparam logic [CNT_W-1:0] CNT_CAP_END   = CNT_W'(DATA_W - 1);

    logic [FW-1:0]     sh;
    logic [DATA_W-1:0] cap;
    logic [CNT_W-1:0]  bit_cnt;

    // MOSI comes straight off a flop; the shifter is cleared outside frames
    // so the line idles low.
    assign mosi       = sh[FW-1];
    assign cap_next   = {cap[DATA_W-2:0], miso};
    assign frame_last = frame_en && (bit_cnt == CNT_FRAME_END);
    assign cap_last   = cap_en && (bit_cnt == CNT_CAP_END);

    // Frame cycle 0 repeats the MSB (command-select cycle), so no shift
    // happens at the end of count 0; the word is cleared after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            cap     <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sh      <= load_word;
            bit_cnt <= '0;
        end else if (frame_en) begin
            if (bit_cnt == CNT_FRAME_END) begin
                sh      <= '0;
                bit_cnt <= '0;
            end else begin
                if (bit_cnt != '0)
                    sh <= {sh[FW-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (cap_en) begin
            cap     <= cap_next;
            bit_cnt <= (bit_cnt == CNT_CAP_END) ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_ram_master.sv
// SPI RAM master: turns parallel write/read requests into two-frame SPI
// command sequences and returns read data captured from MISO.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              done,
    output logic              MOSI,
    output logic              SS_n,
    input  logic              MISO
);

    localparam int FW = ADDR_W + CMD_W;
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    if (DATA_W != ADDR_W) begin : g_chk_dw
        $error("spi_ram_master: DATA_W (%0d) must equal ADDR_W (%0d)", DATA_W, ADDR_W);
    end
    if (RD_LAT < 0 || RD_LAT > 7) begin : g_chk_lat
        $error("spi_ram_master: RD_LAT (%0d) outside 0..7", RD_LAT);
    end
    if (GAP < 1 || GAP > 15) begin : g_chk_gap
        $error("spi_ram_master: GAP (%0d) outside 1..15", GAP);
    end

    state_t            state;
    logic              phase;       // 0: first frame of the pair, 1: second
    logic [3:0]        gcnt;        // shared gap / read-latency counter
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;
    logic              ss_q, ready_q, done_q, rv_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept, load, frame_last, cap_last;
    logic [FW-1:0]     load_word;
    logic [DATA_W-1:0] cap_next;

    assign accept     = (state == ST_IDLE) && ready_q && req_valid;
    assign req_ready  = ready_q;
    assign SS_n       = ss_q;
    assign done       = done_q;
    assign resp_valid = rv_q;
    assign resp_rdata = rdata_q;

    // Pick the word for the frame about to start. The first frame is built
    // from the live request (address is never needed again), the second
    // from the latched copy.
    always_comb begin
        load      = 1'b0;
        load_word = '0;
        if (accept) begin
            load      = 1'b1;
            load_word = {(req_write ? CMD_WR_ADDR : CMD_RD_ADDR), req_addr};
        end else if (state == ST_GAP && gcnt == GAP_LAST && !phase) begin
            load      = 1'b1;
            load_word = lat_write ? {CMD_WR_DATA, lat_wdata}
                                  : {CMD_RD_DATA, {ADDR_W{1'b0}}};
        end
    end

    spi_frame_shifter #(
        .FW     (FW),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_word  (load_word),
        .frame_en   (state == ST_FRAME),
        .cap_en     (state == ST_RD_CAP),
        .miso       (MISO),
        .mosi       (MOSI),
        .frame_last (frame_last),
        .cap_last   (cap_last),
        .cap_next   (cap_next)
    );

    // Transaction sequencer with registered SS_n / handshake / pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            gcnt      <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            ss_q      <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            rv_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_FRAME;
                        phase     <= 1'b0;
                        lat_write <= req_write;
                        lat_wdata <= req_wdata;
                        ss_q      <= 1'b0;
                        ready_q   <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (frame_last) begin
                        gcnt <= '0;
                        if (phase && !lat_write) begin
                            // read-data frame keeps SS_n low through capture
                            state <= (RD_LAT == 0) ? ST_RD_CAP : ST_RD_WAIT;
                        end else begin
                            state <= ST_GAP;
                            ss_q  <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (gcnt == LAT_LAST)
                        state <= ST_RD_CAP;
                    else
                        gcnt <= gcnt + 4'd1;
                end
                ST_RD_CAP: begin
                    if (cap_last) begin
                        state   <= ST_GAP;
                        ss_q    <= 1'b1;
                        rv_q    <= 1'b1;
                        rdata_q <= cap_next;
                        gcnt    <= '0;
                    end
                end
                ST_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            state <= ST_FRAME;
                            ss_q  <= 1'b0;
                        end else begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: one instance with GAP=2/RD_LAT=1 and
// one with GAP=1/RD_LAT=0, a frame decoder and a tiny RAM slave model.
module tb_spi_ram_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       v1, w1, rdy1, rv1, dn1, mo1, ss1, mi1;
    logic [7:0] a1, d1, rd1;
    logic       v2, w2, rdy2, rv2, dn2, mo2, ss2, mi2;
    logic [7:0] a2, d2, rd2;

    spi_ram_master #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_write(w1), .req_addr(a1), .req_wdata(d1), .resp_valid(rv1),
        .resp_rdata(rd1), .done(dn1), .MOSI(mo1), .SS_n(ss1), .MISO(mi1));

    spi_ram_master #(.ADDR_W(8), .DATA_W(8), .RD_LAT(0), .GAP(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_write(w2), .req_addr(a2), .req_wdata(d2), .resp_valid(rv2),
        .resp_rdata(rd2), .done(dn2), .MOSI(mo2), .SS_n(ss2), .MISO(mi2));

    int checks = 0;
    int failures = 0;

    logic       log_ss [0:127];
    logic       log_mo [0:127];
    int         n_log, done_at, rv_cnt, rv_cyc;
    logic [7:0] rv_data;
    int         nfr, mo_hi_bad;
    logic [9:0] fr_word [0:3];
    int         fr_len [0:3];
    int         gap_len [0:3];
    logic [7:0] mem [0:255];

    function automatic logic get_rdy(input bit sel); return sel ? rdy2 : rdy1; endfunction
    function automatic logic get_ss(input bit sel);  return sel ? ss2 : ss1;   endfunction
    function automatic logic get_mo(input bit sel);  return sel ? mo2 : mo1;   endfunction
    function automatic logic get_rv(input bit sel);  return sel ? rv2 : rv1;   endfunction
    function automatic logic get_dn(input bit sel);  return sel ? dn2 : dn1;   endfunction
    function automatic logic [7:0] get_rd(input bit sel); return sel ? rd2 : rd1; endfunction

    task automatic drive(input bit sel, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (sel) begin v2 = v; w2 = w; a2 = a; d2 = d; end
        else     begin v1 = v; w1 = w; a1 = a; d1 = d; end
    endtask

    task automatic set_miso(input bit sel, input logic b);
        if (sel) mi2 = b; else mi1 = b;
    endtask

    // Split the logged SS_n/MOSI trace into frames (bits 9..0 appear on
    // frame cycles 1..10) and SS_n-high gaps (done cycle excluded).
    task automatic decode();
        int c, s;
        nfr = 0; mo_hi_bad = 0; c = 0;
        for (int i = 0; i < 4; i++) begin
            fr_word[i] = '0; fr_len[i] = 0; gap_len[i] = 0;
        end
        while (c < n_log) begin
            if (log_ss[c] == 1'b0) begin
                s = c;
                while (c < n_log && log_ss[c] == 1'b0) c++;
                if (nfr < 4) begin
                    fr_len[nfr] = c - s;
                    for (int b = 0; b < 10; b++)
                        if (s + 1 + b < n_log) fr_word[nfr][9-b] = log_mo[s+1+b];
                    nfr++;
                end
            end else begin
                if (log_mo[c] !== 1'b0) mo_hi_bad++;
                if (nfr > 0 && c < n_log - 1) gap_len[nfr-1]++;
                c++;
            end
        end
    endtask

    // Issue one request, log outputs from the accept edge (cycle 0) to done,
    // and drive MISO in the expected capture window of the read-data frame.
    task automatic run_req(input bit sel, input bit wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] miso_byte,
                           input int gap, input int rdlat);
        int c, ws;
        bit seen;
        c = 0;
        @(negedge clk);
        while (get_rdy(sel) !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        checks++;
        if (get_rdy(sel) !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: req_ready=%b, required 1", get_rdy(sel));
        end
        drive(sel, 1'b1, wr, addr, wdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~wr, ~addr, ~wdata);
        ws = 11 + gap + 11 + rdlat;
        n_log = 0; rv_cnt = 0; rv_cyc = -1; rv_data = '0; seen = 0; done_at = -1;
        for (int k = 0; k < 128 && !seen; k++) begin
            set_miso(sel, (!wr && k >= ws && k < ws + 8) ? miso_byte[7-(k-ws)] : 1'b0);
            @(negedge clk);
            log_ss[k] = get_ss(sel);
            log_mo[k] = get_mo(sel);
            if (get_rv(sel) === 1'b1) begin rv_cnt++; rv_cyc = k; rv_data = get_rd(sel); end
            n_log = k + 1;
            if (get_dn(sel) === 1'b1) begin seen = 1; done_at = k; end
            else begin @(posedge clk); #1; end
        end
        set_miso(sel, 1'b0);
        decode();
        if (wr && nfr >= 2) mem[fr_word[0][7:0]] = fr_word[1][7:0];
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 8'h00, 8'h00); drive(1, 0, 0, 8'h00, 8'h00);
        mi1 = 1'b0; mi2 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ss1, mo1, rdy1, rv1, dn1} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctl1: {ss,mosi,rdy,rv,done}=%b, required 10000", {ss1, mo1, rdy1, rv1, dn1});
        end
        checks++;
        if (rd1 !== 8'h00) begin failures++; $display("FAIL reset_rdata: %h, required 00", rd1); end
        checks++;
        if ({ss2, mo2, rdy2, rv2, dn2} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctl2: {ss,mosi,rdy,rv,done}=%b, required 10000", {ss2, mo2, rdy2, rv2, dn2});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        run_req(0, 1, 8'h3C, 8'hA5, 8'h00, 2, 1);
        checks++;
        if (nfr !== 2) begin failures++; $display("FAIL wr_nframes: %0d, required 2", nfr); end
        checks++;
        if (fr_word[0] !== 10'h03C || fr_word[1] !== 10'h1A5) begin
            failures++;
            $display("FAIL wr_words: %h %h, required 03c 1a5", fr_word[0], fr_word[1]);
        end
        checks++;
        if (fr_len[0] !== 11 || fr_len[1] !== 11) begin
            failures++;
            $display("FAIL wr_frame_len: %0d %0d, required 11 11", fr_len[0], fr_len[1]);
        end
        checks++;
        if (gap_len[0] !== 2 || gap_len[1] !== 2) begin
            failures++;
            $display("FAIL wr_gaps: %0d %0d, required 2 2", gap_len[0], gap_len[1]);
        end
        checks++;
        if (done_at !== 26) begin failures++; $display("FAIL wr_latency: %0d, required 26", done_at); end
        checks++;
        if (rv_cnt !== 0) begin failures++; $display("FAIL wr_no_resp: resp pulses %0d, required 0", rv_cnt); end
    endtask

    task automatic test_read();
        run_req(0, 0, 8'h3C, 8'h00, 8'hA5, 2, 1);
        checks++;
        if (fr_word[0] !== 10'h23C || fr_word[1] !== 10'h300) begin
            failures++;
            $display("FAIL rd_words: %h %h, required 23c 300", fr_word[0], fr_word[1]);
        end
        checks++;
        if (fr_len[1] !== 20) begin failures++; $display("FAIL rd_frame2_len: %0d, required 20", fr_len[1]); end
        checks++;
        if (rv_cnt !== 1 || rv_cyc !== 33) begin
            failures++;
            $display("FAIL rd_resp_timing: count %0d at %0d, required 1 at 33", rv_cnt, rv_cyc);
        end
        checks++;
        if (rv_data !== 8'hA5) begin failures++; $display("FAIL rd_data: %h, required a5", rv_data); end
        checks++;
        if (done_at !== 35) begin failures++; $display("FAIL rd_latency: %0d, required 35", done_at); end
        checks++;
        if (mo_hi_bad !== 0) begin failures++; $display("FAIL rd_mosi_idle: %0d high cycles, required 0", mo_hi_bad); end
    endtask

    task automatic test_back_to_back();
        int h [0:2];
        int dd [0:2];
        int nh, nd, bad_rdy, run, max_run, c;
        bit in_txn;
        nh = 0; nd = 0; bad_rdy = 0; run = 0; max_run = 0; in_txn = 0;
        for (int i = 0; i < 3; i++) begin h[i] = -1; dd[i] = -1; end
        c = 0;
        @(negedge clk);
        while (rdy1 !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        drive(0, 1, 1, 8'h55, 8'hAA);
        for (int k = 0; k < 100 && nd < 2; k++) begin
            if (k > 0) @(negedge clk);
            if (ss1 === 1'b0) begin run++; if (run > max_run) max_run = run; end
            else run = 0;
            if (in_txn) begin
                if (dn1 === 1'b1) begin dd[nd] = k; nd++; in_txn = 0; end
                else if (rdy1 !== 1'b0) bad_rdy++;
            end
            if (nd == 2) drive(0, 0, 0, 8'h00, 8'h00);
            else if (!in_txn && rdy1 === 1'b1 && nh < 3) begin h[nh] = k; nh++; in_txn = 1; end
        end
        drive(0, 0, 0, 8'h00, 8'h00);
        checks++;
        if (nh !== 2 || nd !== 2) begin
            failures++;
            $display("FAIL b2b_count: accepts %0d dones %0d, required 2 2", nh, nd);
        end
        checks++;
        if (h[1] + 1 - dd[0] !== 1) begin
            failures++;
            $display("FAIL b2b_accept_after_done: %0d cycles, required 1", h[1] + 1 - dd[0]);
        end
        checks++;
        if (bad_rdy !== 0) begin failures++; $display("FAIL b2b_ready_low: %0d bad cycles, required 0", bad_rdy); end
        checks++;
        if (max_run !== 11) begin failures++; $display("FAIL b2b_ss_run: %0d, required 11", max_run); end
        checks++;
        if (dd[1] - h[1] - 1 !== 26) begin
            failures++;
            $display("FAIL b2b_latency2: %0d, required 26", dd[1] - h[1] - 1);
        end
    endtask

    task automatic test_reset_mid();
        int c, bad;
        c = 0; bad = 0;
        @(negedge clk);
        while (rdy1 !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        drive(0, 1, 1, 8'hFF, 8'h34);
        @(posedge clk); #1;
        drive(0, 0, 0, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (ss1 !== 1'b0 || mo1 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: ss=%b mosi=%b, required 0 1", ss1, mo1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ss1 !== 1'b1 || mo1 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: ss=%b mosi=%b, required 1 0", ss1, mo1);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dn1 !== 1'b0 || ss1 !== 1'b1 || rv1 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet: %0d bad cycles, required 0", bad); end
        run_req(0, 1, 8'h00, 8'hFF, 8'h00, 2, 1);
        checks++;
        if (fr_word[0] !== 10'h000 || fr_word[1] !== 10'h1FF || done_at !== 26) begin
            failures++;
            $display("FAIL rstmid_after: %h %h done %0d, required 000 1ff done 26", fr_word[0], fr_word[1], done_at);
        end
    endtask

    task automatic test_lat0();
        run_req(1, 0, 8'h5A, 8'h00, 8'h81, 1, 0);
        checks++;
        if (fr_word[0] !== 10'h25A || fr_word[1] !== 10'h300) begin
            failures++;
            $display("FAIL lat0_words: %h %h, required 25a 300", fr_word[0], fr_word[1]);
        end
        checks++;
        if (fr_len[1] !== 19) begin failures++; $display("FAIL lat0_frame2_len: %0d, required 19", fr_len[1]); end
        checks++;
        if (gap_len[0] !== 1 || gap_len[1] !== 1) begin
            failures++;
            $display("FAIL lat0_gaps: %0d %0d, required 1 1", gap_len[0], gap_len[1]);
        end
        checks++;
        if (rv_data !== 8'h81 || rv_cnt !== 1) begin
            failures++;
            $display("FAIL lat0_data: %h x%0d, required 81 x1", rv_data, rv_cnt);
        end
        checks++;
        if (done_at !== 32) begin failures++; $display("FAIL lat0_latency: %0d, required 32", done_at); end
    endtask

    task automatic test_boundary();
        int hi;
        hi = 0;
        run_req(0, 1, 8'h00, 8'hC3, 8'h00, 2, 1); hi += mo_hi_bad;
        run_req(0, 1, 8'hFF, 8'h3C, 8'h00, 2, 1); hi += mo_hi_bad;
        checks++;
        if (fr_word[0] !== 10'h0FF || fr_word[1] !== 10'h13C) begin
            failures++;
            $display("FAIL bnd_wr_ff: %h %h, required 0ff 13c", fr_word[0], fr_word[1]);
        end
        run_req(0, 0, 8'h00, 8'h00, mem[8'h00], 2, 1); hi += mo_hi_bad;
        checks++;
        if (rv_data !== 8'hC3) begin failures++; $display("FAIL bnd_rd_00: %h, required c3", rv_data); end
        run_req(0, 0, 8'hFF, 8'h00, mem[8'hFF], 2, 1); hi += mo_hi_bad;
        checks++;
        if (rv_data !== 8'h3C || fr_word[0] !== 10'h2FF) begin
            failures++;
            $display("FAIL bnd_rd_ff: data %h word %h, required 3c 2ff", rv_data, fr_word[0]);
        end
        checks++;
        if (hi !== 0) begin failures++; $display("FAIL bnd_mosi_idle: %0d high cycles, required 0", hi); end
        repeat (4) @(negedge clk);
        checks++;
        if (rd1 !== 8'h3C) begin failures++; $display("FAIL bnd_rdata_hold: %h, required 3c", rd1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_lat0();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
